zeroriscy_serial_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for the zero-riscy EX stage, implementing RV32M DIV/DIVU/REM/REMU. The ID stage decodes the `MD_OP_DIV`/`MD_OP_REM` operator codes and holds `div_en_i` high until this block returns `ready_o`. The block produces one 32-bit result after a fixed 33-cycle latency and then returns to idle. ALU operations continue to use the ALU; this block handles division only.

---
 rtl/zeroriscy_defines.sv | 15 +
 rtl/zeroriscy_serial_divider.sv | 115 +++++++++++
 tb/tb_zeroriscy_serial_divider.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_defines.sv
// rtl/zeroriscy_defines.sv - shared zero-riscy operator codes and EX-stage state types
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_CALC   = 2'd1,
        DIV_FINISH = 2'd2
    } div_state_t;

endpackage

// File: rtl/zeroriscy_serial_divider.sv
// rtl/zeroriscy_serial_divider.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module zeroriscy_serial_divider
    import zeroriscy_defines::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en_i,
    input  logic [1:0]       operator_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // The most negative value maps onto itself, which is exactly the unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    div_state_t        r_state;
    logic [1:0]        r_op;
    logic              r_signed;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_b_zero;
    logic [CNT_W-1:0]  r_count;
    logic [WIDTH-1:0]  r_b_mag;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_quo;

    logic [WIDTH:0]    w_trial;
    logic [WIDTH:0]    w_diff;
    logic              w_neg_q;
    logic              w_neg_r;
    logic              w_negate;
    logic [WIDTH-1:0]  w_raw;
    logic [WIDTH-1:0]  w_result;

    // Since rem < |b| on entry, a set bit WIDTH in the difference means the trial was smaller than |b|.
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_b_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= DIV_IDLE;
            r_op     <= '0;
            r_signed <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_b_zero <= 1'b0;
            r_count  <= '0;
            r_b_mag  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (div_en_i) begin
                        r_op     <= operator_i;
                        r_signed <= signed_i;
                        r_sign_q <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
                        r_sign_r <= op_a_i[WIDTH-1];
                        r_b_zero <= (op_b_i == '0);
                        r_b_mag  <= magnitude(op_b_i, signed_i);
                        r_quo    <= magnitude(op_a_i, signed_i);
                        r_rem    <= '0;
                        r_count  <= CNT_W'(WIDTH - 1);
                        r_state  <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    if (!div_en_i) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_rem   <= w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_quo   <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == '0) begin
                            r_state <= DIV_FINISH;
                        end
                    end
                end
                DIV_FINISH: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Divide by zero leaves an all-ones quotient that must stay unsigned-looking.
    assign w_neg_q  = r_signed & r_sign_q & ~r_b_zero;
    assign w_neg_r  = r_signed & r_sign_r;
    assign w_negate = (r_op == MD_OP_REM) ? w_neg_r : w_neg_q;
    assign w_raw    = (r_op == MD_OP_REM) ? r_rem : r_quo;
    assign w_result = w_negate ? negate(w_raw) : w_raw;

    // The request level gates the pulse so an abort in FINISH never reports a result.
    assign ready_o  = (r_state == DIV_FINISH) && div_en_i;
    assign result_o = ready_o ? w_result : '0;
    assign busy_o   = (r_state != DIV_IDLE);

endmodule

// File: tb/tb_zeroriscy_serial_divider.sv
// tb/tb_zeroriscy_serial_divider.sv - scoreboard bench for zeroriscy_serial_divider
module tb_zeroriscy_serial_divider;

    logic        clk;
    logic        rst_n;
    logic        div_en_i;
    logic [1:0]  operator_i;
    logic        signed_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        ready_o;
    logic [31:0] result_o;
    logic        busy_o;

    zeroriscy_serial_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en_i   (div_en_i),
        .operator_i (operator_i),
        .signed_i   (signed_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .busy_o     (busy_o)
    );

    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_REM = 2'b11;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ready_o) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ready: got result 0x%08h, expected no ready pulse (cycle %0d)", result_o, cyc);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check({e.name, "_result"}, result_o, e.res);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        int   busy_cnt;
        exp_t e;
        @(posedge clk); #1;
        div_en_i   = 1'b1;
        operator_i = op;
        signed_i   = sgn;
        op_a_i     = a;
        op_b_i     = b;
        e.res  = exp_res;
        e.cyc  = cyc + 33;
        e.name = name;
        q_exp.push_back(e);
        busy_cnt = 0;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                op_a_i   = ~a;
                op_b_i   = b ^ 32'h5;
                signed_i = ~sgn;
            end
            if (busy_o) busy_cnt++;
        end
        @(posedge clk); #1;
        div_en_i = 1'b0;
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({name, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        div_en_i   = 1'b0;
        operator_i = OP_DIV;
        signed_i   = 1'b0;
        op_a_i     = '0;
        op_b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  {31'd0, ready_o}, 32'd0);
        check("reset_busy",   {31'd0, busy_o},  32'd0);
        check("reset_result", result_o,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7",   OP_DIV, 1'b0, 32'd100,        32'd7,          32'd14);
        run_op("remu_100_7",   OP_REM, 1'b0, 32'd100,        32'd7,          32'd2);
        run_op("div_m7_2",     OP_DIV, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD);
        run_op("rem_m7_2",     OP_REM, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF);
        run_op("rem_7_m2",     OP_REM, 1'b1, 32'd7,          32'hFFFFFFFE,   32'd1);
        run_op("div_7_m2",     OP_DIV, 1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD);
        run_op("div_m7_m2",    OP_DIV, 1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3);
        run_op("div_m5_0",     OP_DIV, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF);
        run_op("rem_m5_0",     OP_REM, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB);
        run_op("divu_9_0",     OP_DIV, 1'b0, 32'd9,          32'd0,          32'hFFFFFFFF);
        run_op("remu_9_0",     OP_REM, 1'b0, 32'd9,          32'd0,          32'd9);
        run_op("div_ovf",      OP_DIV, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000);
        run_op("rem_ovf",      OP_REM, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0);

        // Abort mid-calculation: no expectation is queued, so any ready pulse is flagged.
        @(posedge clk); #1;
        div_en_i   = 1'b1;
        operator_i = OP_DIV;
        signed_i   = 1'b0;
        op_a_i     = 32'd1000;
        op_b_i     = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        div_en_i = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", {31'd0, busy_o}, 32'd0);
        repeat (30) @(posedge clk);
        run_op("divu_max_1",   OP_DIV, 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF);

        @(posedge clk); #1;
        div_en_i   = 1'b1;
        operator_i = OP_DIV;
        signed_i   = 1'b0;
        op_a_i     = 32'd50;
        op_b_i     = 32'd5;
        repeat (20) @(posedge clk);
        #2;
        rst_n    = 1'b0;
        div_en_i = 1'b0;
        #1;
        check("async_rst_busy",   {31'd0, busy_o},  32'd0);
        check("async_rst_ready",  {31'd0, ready_o}, 32'd0);
        check("async_rst_result", result_o,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_10_3",    OP_DIV, 1'b0, 32'd10,         32'd3,          32'd3);

        repeat (5) @(posedge clk);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
